// File: rtl/cycle_seq_pkg.sv
// cycle_seq_pkg: shared encodings for the CPU cycle sequencer.
// Holds the FSM state type, the one-hot T-state and M-cycle constants
// and the bus widths used by the sequencer and its T-state ring.
package cycle_seq_pkg;

  localparam int STEP_W  = 4;
  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

  localparam logic [STEP_W-1:0]  T1 = 4'b0001;
  localparam logic [STEP_W-1:0]  T2 = 4'b0010;
  localparam logic [STEP_W-1:0]  T3 = 4'b0100;
  localparam logic [STEP_W-1:0]  T4 = 4'b1000;

  localparam logic [COUNT_W-1:0] M1 = 8'b0000_0001;
  localparam logic [COUNT_W-1:0] M8 = 8'b1000_0000;

endpackage

// File: rtl/t_state_ring.sv
// t_state_ring: 4-bit one-hot T-state ring (T1->T2->T3->T4->T1).
// The ring freezes while hold is high so bus wait states stretch the
// current T-state; reset returns it to T1.
module t_state_ring
  import cycle_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  output logic [STEP_W-1:0] step
);

  // Rotate the one-hot T-state each clock unless held
  always_ff @(posedge clk) begin
    if (reset) begin
      step <= T1;
    end else if (!hold) begin
      step <= {step[STEP_W-2:0], step[STEP_W-1]};
    end else begin
      step <= step;
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: central T-state / M-cycle sequencer of the control unit.
// Runs the FETCH / RUN / HALT loop, closes the instruction on the decoders'
// fetch request and forces a refetch (sticky fault) on instructions that
// run past M8.
// Optional feature macro: CYCLE_SEQ_BUS_WAIT_EN -- when defined, a low
// i_Bus_Ready during T2 freezes the sequencer and raises o_Stall.
module cycle_sequencer
  import cycle_seq_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Fetch,
  input  logic               i_Halt,
  input  logic               i_Int_Pending,
  input  logic               i_Bus_Ready,
  output logic [STEP_W-1:0]  o_Cycle_Step,
  output logic [COUNT_W-1:0] o_Cycle_Count,
  output logic               o_Active,
  output logic               o_IR_Load,
  output logic               o_PC_Fetch,
  output logic               o_M_Tick,
  output logic               o_Stall,
  output logic               o_Fault
);

  logic [STEP_W-1:0]  step_s;
  logic               hold_s;
  logic               at_t4_s;
  logic               ir_load_s;
  seq_state_e         state_r;
  seq_state_e         state_n_s;
  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] count_n_s;
  logic               fault_r;
  logic               fault_n_s;
  logic               active_r;
  logic               pc_fetch_r;
  logic               stall_r;

`ifdef CYCLE_SEQ_BUS_WAIT_EN
  // Wait states are only inserted in T2, in every state
  assign hold_s = (step_s == T2) & ~i_Bus_Ready;
`else
  logic unused_bus_ready_s;
  assign unused_bus_ready_s = i_Bus_Ready;
  assign hold_s             = 1'b0;
`endif

  t_state_ring u_ring (
    .clk   (i_Clk),
    .reset (i_Reset),
    .hold  (hold_s),
    .step  (step_s)
  );

  // hold_s can only be high in T2, so a T4 clock always completes
  assign at_t4_s = (step_s == T4);

  // Next state, next M-cycle count, fault latch and IR load decision
  always_comb begin
    state_n_s = state_r;
    count_n_s = count_r;
    fault_n_s = fault_r;
    ir_load_s = 1'b0;
    if (at_t4_s) begin
      case (state_r)
        ST_FETCH: begin
          ir_load_s = 1'b1;
          state_n_s = ST_RUN;
          count_n_s = M1;
        end
        ST_RUN: begin
          if (i_Fetch) begin
            count_n_s = M1;
            if (i_Halt) begin
              state_n_s = ST_HALT;
            end else begin
              ir_load_s = 1'b1;
            end
          end else if (count_r == M8) begin
            // Runaway instruction: flag it and refetch from M1
            fault_n_s = 1'b1;
            ir_load_s = 1'b1;
            count_n_s = M1;
          end else begin
            count_n_s = {count_r[COUNT_W-2:0], 1'b0};
          end
        end
        ST_HALT: begin
          count_n_s = M1;
          if (i_Int_Pending) begin
            state_n_s = ST_FETCH;
          end else begin
            state_n_s = ST_HALT;
          end
        end
        default: begin
          state_n_s = ST_FETCH;
          count_n_s = M1;
        end
      endcase
    end else begin
      state_n_s = state_r;
      count_n_s = count_r;
    end
  end

  // Sequencer registers; decoder enables follow the next state so they
  // change on the same edge as the FSM
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r    <= ST_FETCH;
      count_r    <= M1;
      fault_r    <= 1'b0;
      active_r   <= 1'b0;
      pc_fetch_r <= 1'b1;
      stall_r    <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      count_r    <= count_n_s;
      fault_r    <= fault_n_s;
      active_r   <= (state_n_s == ST_RUN);
      pc_fetch_r <= (state_n_s == ST_FETCH);
      stall_r    <= hold_s;
    end
  end

  assign o_Cycle_Step  = step_s;
  assign o_Cycle_Count = count_r;
  assign o_Active      = active_r;
  assign o_PC_Fetch    = pc_fetch_r;
  assign o_Stall       = stall_r;
  assign o_Fault       = fault_r;
  assign o_IR_Load     = ir_load_s;
  assign o_M_Tick      = at_t4_s & ~hold_s;

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Central timing sequencer for the CPU control unit. Generates the one-hot T-state (`Cycle_Step`) and one-hot M-cycle (`Cycle_Count`) buses consumed by every opcode-group microcode decoder. Closes the instruction loop by acting on the decoders' OR-combined fetch request, and manages power-on fetch, HALT/wake, bus wait stalls and runaway-instruction recovery.

## Interface
- No parameters; T-states per M-cycle = 4, max M-cycles per instruction = 8 (constants in package).
- `i_Clk` in 1 — system clock.
- `i_Reset` in 1 — synchronous, active-high reset.
- `i_Fetch` in 1 — OR of decoder fetch outputs; current M-cycle is the instruction's last.
- `i_Halt` in 1 — decoded HALT; only meaningful together with `i_Fetch`.
- `i_Int_Pending` in 1 — any enabled interrupt pending; wakes from HALT.
- `i_Bus_Ready` in 1 — memory ready; low inserts wait states (macro-gated).
- `o_Cycle_Step` out 4 — one-hot T-state, bit0=T1 … bit3=T4.
- `o_Cycle_Count` out 8 — one-hot M-cycle, bit0=M1 … bit7=M8.
- `o_Active` out 1 — decoders enabled; high only in RUN.
- `o_IR_Load` out 1 — instruction register captures data bus this clock.
- `o_PC_Fetch` out 1 — PC drives address bus during sequencer-owned fetch M-cycle.
- `o_M_Tick` out 1 — one-clock pulse at completion of each M-cycle.
- `o_Stall` out 1 — wait state in progress.
- `o_Fault` out 1 — sticky: instruction exceeded M8.

## Operation
- States: FETCH, RUN, HALT.
- FETCH: one M-cycle; `o_Active`=0, `o_PC_Fetch`=1, `o_IR_Load`=1 at T4; next RUN with Count=M1.
- RUN: `o_Active`=1. At T4:
  - `i_Fetch`=1, `i_Halt`=0 → `o_IR_Load`=1, Count→M1, stay RUN.
  - `i_Fetch`=1, `i_Halt`=1 → no IR load, Count→M1, go HALT.
  - `i_Fetch`=0 → Count shifts left one.
  - `i_Fetch`=0 and Count=M8 → `o_Fault` set, `o_IR_Load`=1 (forced refetch), Count→M1.
- HALT: `o_Active`=0; Step keeps cycling, Count held M1, `o_M_Tick` still pulses. At T4 with `i_Int_Pending`=1 → FETCH.
- `i_Fetch`/`i_Halt` ignored outside RUN; `i_Int_Pending` ignored outside HALT.
- `o_Fault` cleared only by reset.

## Timing
- Step advances T1→T2→T3→T4→T1 every clock unless stalled; Count/state change only on the T4→T1 edge.
- `o_IR_Load`, `o_M_Tick` combinational from registered Step/state and current inputs (valid in T4 only); all else registered.
- `o_M_Tick` = T4 & ~stall.
- Reset values: Step=0001, Count=0000_0001, state=FETCH, `o_Active`=0, `o_PC_Fetch`=1, `o_IR_Load`=0, `o_M_Tick`=0, `o_Stall`=0, `o_Fault`=0.
- First `o_IR_Load` = 4th clock after reset deassertion; first `o_Active` on the 5th.
- Reset mid-M-cycle: abandons instruction, returns to reset values next clock; reset dominates all inputs.

## Configuration
- `CYCLE_SEQ_BUS_WAIT_EN` defined: in T2 with `i_Bus_Ready`=0, Step/Count/state freeze and `o_Stall`=1; resumes T3 the clock after `i_Bus_Ready`=1. Unlimited waits; applies in all states.
- Undefined: `i_Bus_Ready` ignored, `o_Stall` tied 0.

## Structure
- Package `cycle_seq_pkg`: state encoding (FETCH/RUN/HALT), one-hot constants T1–T4, M1, M8, widths STEP_W=4, COUNT_W=8.
- Sub-module `t_state_ring`: 4-bit one-hot ring with hold enable, reset to T1; sequencer owns Count and FSM.

## Test plan
- Reset release, `i_Fetch`=0 → IR_Load at clock 4 with `o_PC_Fetch`=1; clock 5 `o_Active`=1, Step=0001, Count=0000_0001.
- RUN, `i_Fetch`=1 at T4 of M3 → Count 00000100→00000001, `o_IR_Load`=1 that T4, three `o_M_Tick` pulses.
- `i_Fetch`=`i_Halt`=1 at T4 → HALT, `o_Active`=0, no IR_Load; `i_Int_Pending`=1 ten clocks later → FETCH at next T1, IR_Load at its T4, then RUN.
- `i_Fetch` held 0 for 8 M-cycles → at M8 T4 `o_Fault`=1, `o_IR_Load`=1, Count=M1; Fault persists until reset.
- Macro on: `i_Bus_Ready`=0 for 3 clocks at T2 → Step 0010 held 4 clocks, `o_Stall`=1 for 3, no `o_M_Tick`; macro off: same stimulus, no stall.
- `i_Reset` at T3 of M2 → next clock Step=0001, Count=00000001, state FETCH, `o_Fault`=0.
